// File: rtl/led_pattern_gen.sv
// LED pattern generator: eight animated patterns stepped by a speed-scaled divider,
// with pause, invert, glitch-free mode switching and tick/wrap status pulses.
module led_pattern_gen #(
    parameter int unsigned N_LEDS   = 10,
    parameter int unsigned DOT_W    = 2,
    parameter int unsigned DIV_BASE = 100000,
    parameter int unsigned SPEED_W  = 4
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic [2:0]         mode,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               invert,
    output logic [N_LEDS-1:0]  led_out,
    output logic               tick,
    output logic               wrap
);

    localparam int unsigned PW = $clog2(N_LEDS + 1);
    localparam logic [PW-1:0] M_P = PW'(N_LEDS - DOT_W);
    localparam logic [PW-1:0] N_P = PW'(N_LEDS);
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [N_LEDS-1:0] DOT  = N_LEDS'((1 << DOT_W) - 1);
    localparam logic [N_LEDS-1:0] EVEN = N_LEDS'(32'h5555_5555);

    typedef enum logic [2:0] {
        ModeScan, ModeDual, ModeFill, ModeBlink, ModeAlt, ModeChase, ModeCount, ModeRandom
    } mode_e;

    mode_e             active_mode, active_mode_d;
    logic [31:0]       div, div_d, limit;
    logic [PW-1:0]     pos, pos_d, level, level_d;
    logic              dir, dir_d, phase, phase_d;
    logic [N_LEDS-1:0] cnt, cnt_d, led_d;
    logic [15:0]       lfsr, lfsr_d;
    logic              tick_d, wrap_d, step, switch_mode;

    // Returns {dir, value}; each endpoint is visited for exactly one step.
    function automatic logic [PW:0] bounce(input logic [PW-1:0] v, input logic d,
                                           input logic [PW-1:0] top);
        if (!d) return (v == top) ? {1'b1, top - 1'b1} : {1'b0, v + 1'b1};
        else    return (v == '0)  ? {1'b0, PW'(1)}      : {1'b1, v - 1'b1};
    endfunction

    function automatic logic [N_LEDS-1:0] pattern(input mode_e m, input logic [PW-1:0] p,
                                                  input logic [PW-1:0] l, input logic ph,
                                                  input logic [N_LEDS-1:0] c,
                                                  input logic [15:0] r);
        case (m)
            ModeScan:             return DOT << p;
            ModeDual:             return (DOT << p) | (DOT << (M_P - p));
            ModeFill, ModeChase:  return ~({N_LEDS{1'b1}} << l);
            ModeBlink:            return {N_LEDS{ph}};
            ModeAlt:              return ph ? ~EVEN : EVEN;
            ModeCount:            return c;
            default:              return r[N_LEDS-1:0];
        endcase
    endfunction

    always_comb begin
        limit         = 32'(DIV_BASE) * (32'(speed) + 32'd1);
        step          = !pause && (div >= limit - 32'd1);
        switch_mode   = mode_e'(mode) != active_mode;
        active_mode_d = active_mode;
        div_d         = div;
        pos_d         = pos;
        dir_d         = dir;
        level_d       = level;
        phase_d       = phase;
        cnt_d         = cnt;
        lfsr_d        = lfsr;
        tick_d        = 1'b0;
        wrap_d        = 1'b0;
        if (switch_mode) begin
            // Switch wins over a coincident step and is honoured while paused.
            active_mode_d = mode_e'(mode);
            div_d         = '0;
            pos_d         = '0;
            dir_d         = 1'b0;
            level_d       = '0;
            phase_d       = 1'b0;
            cnt_d         = '0;
            lfsr_d        = SEED;
        end else if (step) begin
            div_d  = '0;
            tick_d = 1'b1;
            case (active_mode)
                ModeScan, ModeDual: begin
                    {dir_d, pos_d} = bounce(pos, dir, M_P);
                    wrap_d = (pos_d == '0);
                end
                ModeFill: begin
                    {dir_d, level_d} = bounce(level, dir, N_P);
                    wrap_d = (level_d == '0);
                end
                ModeBlink, ModeAlt: begin
                    phase_d = ~phase;
                    wrap_d  = phase;
                end
                ModeChase: begin
                    level_d = (level == N_P) ? '0 : level + 1'b1;
                    wrap_d  = (level == N_P);
                end
                ModeCount: begin
                    cnt_d  = cnt + 1'b1;
                    wrap_d = &cnt;
                end
                default: begin
                    lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
                    wrap_d = (lfsr_d == SEED);
                end
            endcase
        end else if (!pause) begin
            div_d = div + 32'd1;
        end
        led_d = pattern(active_mode_d, pos_d, level_d, phase_d, cnt_d, lfsr_d)
                ^ {N_LEDS{invert}};
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            active_mode <= mode_e'(mode);
            div         <= '0;
            pos         <= '0;
            dir         <= 1'b0;
            level       <= '0;
            phase       <= 1'b0;
            cnt         <= '0;
            lfsr        <= SEED;
            led_out     <= '0;
            tick        <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            active_mode <= active_mode_d;
            div         <= div_d;
            pos         <= pos_d;
            dir         <= dir_d;
            level       <= level_d;
            phase       <= phase_d;
            cnt         <= cnt_d;
            lfsr        <= lfsr_d;
            led_out     <= led_d;
            tick        <= tick_d;
            wrap        <= wrap_d;
        end
    end

endmodule
